// File: rtl/execute_stage.sv
// EX stage: ALU, address generation and branch resolution; owns the C/Z flags.
// Define EXEC_MUL_EN to build the 8-step radix-4 unsigned multiplier for func 01100.
module execute_stage #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 3,
  parameter int unsigned FW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [FW-1:0] func,
  input  logic [DW-1:0] op_d1,
  input  logic [DW-1:0] op_d2,
  input  logic [DW-1:0] imm16,
  input  logic [DW-1:0] pc_in,
  input  logic [AW-1:0] rf_wa_in,
  input  logic          checkr_c,
  input  logic          checkr_z,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] alu_out,
  output logic [DW-1:0] store_data,
  output logic [AW-1:0] rf_wa_out,
  output logic          rf_we_out,
  output logic [1:0]    mem_op,
  output logic          br_taken,
  output logic [DW-1:0] br_target,
  output logic [DW-1:0] pc_out,
  output logic          carry_flag,
  output logic          zero_flag
);

  localparam logic [FW-1:0] FnAdd  = FW'(5'b00000);
  localparam logic [FW-1:0] FnNand = FW'(5'b00001);
  localparam logic [FW-1:0] FnLhi  = FW'(5'b00010);
  localparam logic [FW-1:0] FnLw   = FW'(5'b00011);
  localparam logic [FW-1:0] FnSw   = FW'(5'b00100);
  localparam logic [FW-1:0] FnBeq  = FW'(5'b00101);
  localparam logic [FW-1:0] FnJal  = FW'(5'b00110);
  localparam logic [FW-1:0] FnJlr  = FW'(5'b00111);
`ifdef EXEC_MUL_EN
  localparam logic [FW-1:0] FnMul  = FW'(5'b01100);
`endif

  logic          valid_q, we_q, br_q, c_q, z_q;
  logic [DW-1:0] alu_q, sd_q, tgt_q, pc_q;
  logic [AW-1:0] wa_q;
  logic [1:0]    mem_q;

  logic            mul_busy, mul_done;
  logic [2*DW-1:0] mul_prod;

  logic          accept, squash, start_mul, is_mul;
  logic [DW:0]   sum;
  logic [DW-1:0] res_alu, res_tgt;
  logic          res_we, res_br, c_new, z_new;
  logic [1:0]    res_mem;

  assign in_ready  = (!valid_q || out_ready) && !mul_busy;
  assign accept    = in_valid && in_ready;
  // Condition is evaluated against the flags as they stood before this accept.
  assign squash    = (checkr_c && !c_q) || (checkr_z && !z_q);
  assign start_mul = accept && is_mul;
  assign sum       = {1'b0, op_d1} + {1'b0, op_d2};

  always_comb begin
    res_alu = op_d1;
    res_tgt = pc_in + imm16;
    res_we  = 1'b0;
    res_mem = 2'b00;
    res_br  = 1'b0;
    c_new   = c_q;
    z_new   = z_q;
    is_mul  = 1'b0;
    case (func)
      FnAdd: begin
        res_alu = sum[DW-1:0];
        res_we  = 1'b1;
        c_new   = sum[DW];
        z_new   = (sum[DW-1:0] == '0);
      end
      FnNand: begin
        res_alu = ~(op_d1 & op_d2);
        res_we  = 1'b1;
        z_new   = ((op_d1 & op_d2) == '1);
      end
      FnLhi: begin
        res_alu = DW'({op_d2[8:0], 7'b0});
        res_we  = 1'b1;
      end
      FnLw: begin
        res_alu = op_d1 + imm16;
        res_mem = 2'b01;
        res_we  = 1'b1;
      end
      FnSw: begin
        res_alu = op_d2 + imm16;
        res_mem = 2'b10;
      end
      FnBeq: res_br = (op_d1 == op_d2);
      FnJal: begin
        res_alu = pc_in + 1'b1;
        res_br  = 1'b1;
        res_we  = 1'b1;
      end
      FnJlr: begin
        res_alu = pc_in + 1'b1;
        res_tgt = op_d2;
        res_br  = 1'b1;
        res_we  = 1'b1;
      end
`ifdef EXEC_MUL_EN
      FnMul: is_mul = 1'b1;
`endif
      default: ;
    endcase
    if (squash) begin
      res_we  = 1'b0;
      res_mem = 2'b00;
      res_br  = 1'b0;
      c_new   = c_q;
      z_new   = z_q;
      is_mul  = 1'b0;
    end
  end

`ifdef EXEC_MUL_EN
  localparam logic [3:0] MulLast = 4'(DW / 2 - 1);

  logic            busy_q;
  logic [3:0]      cnt_q;
  logic [2*DW-1:0] acc_q, mcand_q, pp;
  logic [DW-1:0]   mplier_q;

  // Retire two multiplier bits per cycle against a left-shifting multiplicand.
  always_comb begin
    case (mplier_q[1:0])
      2'd0:    pp = '0;
      2'd1:    pp = mcand_q;
      2'd2:    pp = mcand_q << 1;
      default: pp = mcand_q + (mcand_q << 1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start_mul) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= {{DW{1'b0}}, op_d1};
      mplier_q <= op_d2;
    end else if (busy_q) begin
      acc_q    <= acc_q + pp;
      mcand_q  <= mcand_q << 2;
      mplier_q <= mplier_q >> 2;
      cnt_q    <= cnt_q + 1'b1;
      if (cnt_q == MulLast) busy_q <= 1'b0;
    end
  end

  assign mul_busy = busy_q;
  assign mul_done = busy_q && (cnt_q == MulLast);
  assign mul_prod = acc_q + pp;
`else
  assign mul_busy = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      alu_q   <= '0;
      sd_q    <= '0;
      wa_q    <= '0;
      we_q    <= 1'b0;
      mem_q   <= 2'b00;
      br_q    <= 1'b0;
      tgt_q   <= '0;
      pc_q    <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
      br_q    <= 1'b0;
    end else if (mul_done) begin
      valid_q <= 1'b1;
      alu_q   <= mul_prod[DW-1:0];
      we_q    <= 1'b1;
      mem_q   <= 2'b00;
      br_q    <= 1'b0;
      c_q     <= |mul_prod[2*DW-1:DW];
      z_q     <= (mul_prod[DW-1:0] == '0);
    end else if (accept) begin
      // A starting multiply leaves the output register empty until it completes.
      valid_q <= !start_mul;
      alu_q   <= res_alu;
      sd_q    <= op_d1;
      wa_q    <= rf_wa_in;
      we_q    <= res_we;
      mem_q   <= res_mem;
      br_q    <= res_br && !start_mul;
      tgt_q   <= res_tgt;
      pc_q    <= pc_in;
      c_q     <= c_new;
      z_q     <= z_new;
    end else if (out_ready) begin
      valid_q <= 1'b0;
      br_q    <= 1'b0;
    end
  end

  assign out_valid  = valid_q;
  assign alu_out    = alu_q;
  assign store_data = sd_q;
  assign rf_wa_out  = wa_q;
  assign rf_we_out  = we_q;
  assign mem_op     = mem_q;
  assign br_taken   = br_q;
  assign br_target  = tgt_q;
  assign pc_out     = pc_q;
  assign carry_flag = c_q;
  assign zero_flag  = z_q;

endmodule
